// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus types for the Dcache/Icache memory arbiter: bus commands, requester
// identity, tag-owner entries and the forwarded request bundle.
package mem_bus_arbiter_pkg;

   localparam int XLEN         = 32;
   localparam int MEM_TAG_W    = 4;
   localparam int NUM_MEM_TAGS = 1 << MEM_TAG_W;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic {
      REQ_DCACHE = 1'b0,
      REQ_ICACHE = 1'b1
   } MEM_REQUESTER;

   typedef struct packed {
      logic         valid;
      MEM_REQUESTER owner;
   } MEM_TAG_ENTRY;

   typedef struct packed {
      logic [1:0]      command;
      logic [XLEN-1:0] addr;
      logic [63:0]     data;
   } mem_req_t;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// mem_tag_table: remembers which requester owns each outstanding load tag (1..15),
// frees an entry when its data returns, and flags re-allocation of a live tag.
module mem_tag_table
   import mem_bus_arbiter_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 alloc_en,
   input  logic [MEM_TAG_W-1:0] alloc_tag,
   input  MEM_REQUESTER         alloc_owner,
   input  logic [MEM_TAG_W-1:0] lookup_tag,
   output logic                 lookup_hit,
   output MEM_REQUESTER         lookup_owner,
   output logic                 conflict
);

   // Slot 0 is never allocated because tag 0 means "not accepted".
   MEM_TAG_ENTRY [NUM_MEM_TAGS-1:0] entry_q;

   always_comb begin
      lookup_hit   = (lookup_tag != '0) && entry_q[lookup_tag].valid;
      lookup_owner = entry_q[lookup_tag].owner;
   end

   // A tag returning in the same cycle it is reissued is being freed, so reuse
   // there is legitimate and not a conflict. Allocation overrides the clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry_q  <= '0;
         conflict <= 1'b0;
      end else begin
         if (lookup_hit)
            entry_q[lookup_tag].valid <= 1'b0;
         if (alloc_en) begin
            entry_q[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
            if (entry_q[alloc_tag].valid && !(lookup_hit && (lookup_tag == alloc_tag)))
               conflict <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between Dcache and Icache with anti-starvation for the Icache
// and tag-owner return steering. Define MEM_ARB_STATS_EN for saturating statistics.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [1:0]           dcache2mem_command,
   input  logic [XLEN-1:0]      dcache2mem_addr,
   input  logic [63:0]          dcache2mem_data,
   output logic [MEM_TAG_W-1:0] mem2dcache_response,
   output logic [63:0]          mem2dcache_data,
   output logic [MEM_TAG_W-1:0] mem2dcache_tag,
   input  logic [1:0]           icache2mem_command,
   input  logic [XLEN-1:0]      icache2mem_addr,
   output logic [MEM_TAG_W-1:0] mem2icache_response,
   output logic [63:0]          mem2icache_data,
   output logic [MEM_TAG_W-1:0] mem2icache_tag,
   output logic [1:0]           proc2mem_command,
   output logic [XLEN-1:0]      proc2mem_addr,
   output logic [63:0]          proc2mem_data,
   input  logic [MEM_TAG_W-1:0] mem2proc_response,
   input  logic [63:0]          mem2proc_data,
   input  logic [MEM_TAG_W-1:0] mem2proc_tag,
   output logic                 tag_conflict
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]     dcache_grant_cnt,
   output logic [CNT_W-1:0]     icache_grant_cnt,
   output logic [CNT_W-1:0]     starve_force_cnt,
   output logic [CNT_W-1:0]     dropped_tag_cnt
`endif
);

   localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic                d_req, i_req, force_i, d_win, i_win;
   logic                accept, alloc_en, ret_hit;
   MEM_REQUESTER        ret_owner;
   logic [STARVE_W-1:0] starve_cnt;
   mem_req_t            gnt_req;

   assign d_req   = (dcache2mem_command != BUS_NONE);
   assign i_req   = (icache2mem_command != BUS_NONE);
   assign force_i = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
   assign i_win   = i_req && (!d_req || force_i);
   assign d_win   = d_req && !i_win;

   always_comb begin
      gnt_req = '{command: BUS_NONE, addr: '0, data: '0};
      if (!reset) begin
         if (i_win)
            gnt_req = '{command: icache2mem_command, addr: icache2mem_addr, data: '0};
         else if (d_win)
            gnt_req = '{command: dcache2mem_command, addr: dcache2mem_addr, data: dcache2mem_data};
      end
   end

   assign proc2mem_command = gnt_req.command;
   assign proc2mem_addr    = gnt_req.addr;
   assign proc2mem_data    = gnt_req.data;

   assign accept   = (gnt_req.command != BUS_NONE) && (mem2proc_response != '0);
   assign alloc_en = accept && (gnt_req.command == BUS_LOAD);

   assign mem2dcache_response = (!reset && d_win) ? mem2proc_response : '0;
   assign mem2icache_response = (!reset && i_win) ? mem2proc_response : '0;

   mem_tag_table u_tag_table (
      .clock       (clock),
      .reset       (reset),
      .alloc_en    (alloc_en),
      .alloc_tag   (mem2proc_response),
      .alloc_owner (i_win ? REQ_ICACHE : REQ_DCACHE),
      .lookup_tag  (mem2proc_tag),
      .lookup_hit  (ret_hit),
      .lookup_owner(ret_owner),
      .conflict    (tag_conflict)
   );

   // Returns to a forgotten tag reach neither cache.
   assign mem2dcache_tag  = (!reset && ret_hit && (ret_owner == REQ_DCACHE)) ? mem2proc_tag : '0;
   assign mem2icache_tag  = (!reset && ret_hit && (ret_owner == REQ_ICACHE)) ? mem2proc_tag : '0;
   assign mem2dcache_data = mem2proc_data;
   assign mem2icache_data = mem2proc_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         starve_cnt <= '0;
      else if (!i_req || (i_win && accept))
         starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
         starve_cnt <= starve_cnt + 1'b1;
   end

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dcache_grant_cnt <= '0;
         icache_grant_cnt <= '0;
         starve_force_cnt <= '0;
         dropped_tag_cnt  <= '0;
      end else begin
         if (accept && d_win && !(&dcache_grant_cnt))
            dcache_grant_cnt <= dcache_grant_cnt + 1'b1;
         if (accept && i_win && !(&icache_grant_cnt))
            icache_grant_cnt <= icache_grant_cnt + 1'b1;
         if (i_win && d_req && !(&starve_force_cnt))
            starve_force_cnt <= starve_force_cnt + 1'b1;
         if ((mem2proc_tag != '0) && !ret_hit && !(&dropped_tag_cnt))
            dropped_tag_cnt <= dropped_tag_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory bus (`proc2mem_*` / `mem2proc_*`, 4-bit transaction tags) between the Dcache and the Icache.
- Grants one requester per cycle and forwards its command.
- Records which requester owns each accepted load tag.
- Steers returning data tags to the owner only.
- Sits between the two cache controllers and `mem`. Each cache still sees the unmodified bus protocol.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the Icache may lose arbitration while requesting before it is forced to win; 0 = strict Dcache priority.
- CNT_W, 16: width of statistics counters (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dcache2mem_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- dcache2mem_addr  in  XLEN  byte address
- dcache2mem_data  in  64  store data
- mem2dcache_response  out  4  accepted tag, 0 = not accepted
- mem2dcache_data  out  64  load data
- mem2dcache_tag  out  4  completing tag owned by Dcache, else 0
- icache2mem_command  in  2  as Dcache (stores are treated as loads-never-issued; Icache issues BUS_LOAD only)
- icache2mem_addr  in  XLEN
- mem2icache_response  out  4
- mem2icache_data  out  64
- mem2icache_tag  out  4
- proc2mem_command  out  2  to memory
- proc2mem_addr  out  XLEN
- proc2mem_data  out  64
- mem2proc_response  in  4
- mem2proc_data  in  64
- mem2proc_tag  in  4
- tag_conflict  out  1  sticky error flag

Behaviour:
- Request: a requester's command != BUS_NONE.
- Grant (combinational):
  - Icache wins iff it requests and either Dcache is idle, or starve_cnt == STARVE_LIMIT with STARVE_LIMIT != 0.
  - Otherwise Dcache wins if requesting.
  - No request: proc2mem_command = BUS_NONE; addr/data = 0.
- Forwarding: the granted requester's command/addr/data drive proc2mem_*. Icache data is forwarded as 0.
- Response routing: mem2proc_response goes to the granted requester's *_response. The other requester sees 0. A requester holds its command until it sees a nonzero response (cache-side rule, unchanged).
- Acceptance: granted command with mem2proc_response != 0.
- Owner table: 15 entries (tags 1..15), each holding valid + owner bit.
  - On an accepted BUS_LOAD: valid[tag] <= 1, owner[tag] <= granted requester.
  - Accepted stores allocate nothing.
  - Allocating an already-valid tag overwrites the entry and sets tag_conflict (sticky until reset).
- Data return: when mem2proc_tag != 0 and valid[mem2proc_tag]:
  - The owner's *_tag = mem2proc_tag; the other's = 0.
  - valid is cleared at the next edge.
  - Invalid entry: both tags 0 and the data is dropped.
  - mem2proc_data is broadcast to both *_data.
- Same-cycle return and allocation of the same tag: allocation wins (entry ends valid with the new owner); the return is still routed using the old owner.
- Starvation counter (STARVE_W = $clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, each cycle the Icache requests and is not accepted.
  - Clears on Icache acceptance or when the Icache is idle.
- Reset (async): table cleared, starve_cnt = 0, tag_conflict = 0. While reset is high, proc2mem_command = BUS_NONE and all *_response/*_tag outputs = 0.
- Reset mid-transaction: in-flight tags are forgotten; their later returns are dropped (both *_tag = 0).
- Latency: grant, forward and routing add zero cycles; table updates are visible the next cycle.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds outputs dcache_grant_cnt, icache_grant_cnt, starve_force_cnt and dropped_tag_cnt, each [CNT_W-1:0].
  - They count, respectively, accepted commands per requester, forced Icache wins, and returns that hit an invalid entry.
  - They saturate, and reset to 0.
- Undefined: these ports and their registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package / sys_defs.svh:
  - MEM_REQUESTER enum (REQ_DCACHE=0, REQ_ICACHE=1).
  - MEM_TAG_ENTRY struct {valid, owner}.
  - Existing BUS_NONE/LOAD/STORE and MEM_TAG width.
- One sub-module, mem_tag_table: owner storage with alloc port, lookup/clear port and conflict detection.
- Grant logic and the starvation counter stay in the top module.

Test Plan:
1. Icache only, LOAD 0x1000; mem responds 3; later returns tag 3, data 0xDEADBEEF_CAFEF00D.
   - Required: mem2icache_response=3; mem2icache_tag=3 with that data; mem2dcache_tag=0.
2. Both request LOAD (D 0x2000, I 0x3000), STARVE_LIMIT=4, mem accepts every cycle with tags 1,2,…
   - Required: Dcache granted 4 cycles; Icache forced on the 5th; mem2dcache_response=0 that cycle.
3. Dcache STORE 0x4000, response 5; then mem2proc_tag=5.
   - Required: no allocation; both *_tag=0.
4. Icache LOAD accepted with tag 7; reset pulsed; then mem2proc_tag=7.
   - Required: both *_tag=0; tag_conflict=0.
5. Dcache LOAD accepted tag 9; Icache LOAD accepted tag 9 before return.
   - Required: tag_conflict=1 and stays; the next return of tag 9 goes to Icache.
6. Same cycle: return of tag 2 (owner Dcache) and Icache acceptance of new tag 2.
   - Required: mem2dcache_tag=2; the entry is now owned by Icache; the next tag-2 return goes to Icache.
